hex_7seg_scan: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode 7-segment display, the multi-digit successor of the team's single-digit hex decoder.
- Latches an N-nibble value once per frame and scans digits with a programmable refresh period and anti-ghosting guard interval.
- Supports per-digit blanking, decimal points and leading-zero blanking.
- Sits between the datapath (counters, ALU results) and the board's shared seg/anode pins.

---
 rtl/hex_7seg_scan_pkg.sv | 26 ++
 rtl/hex_7seg_scan_if.sv | 29 ++
 rtl/hex_7seg_scan_glyph.sv | 17 +
 rtl/hex_7seg_scan.sv | 152 +++++++++++++++
 tb/tb_hex_7seg_scan.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hex_7seg_scan_pkg.sv
// hex7seg_pkg: shared definitions for the 7-segment display drivers.
//   SEG_A..SEG_G : bit index of each segment within a 7-bit pattern
//   GLYPH_TABLE  : 16-entry active-high pattern table, gfedcba order
//   glyph()      : nibble -> active-high segment pattern
package hex7seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // 9 has no segment d and 6 keeps segment a, so the digits match the
  // single-digit decoder already on the boards.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_7seg_scan_if.sv
// hex_7seg_scan_if: groups the datapath-side inputs and display-side outputs
// of the scanner.
//   master : drives en/value/dp/blank/lzb and observes the display pins
//   slave  : the scanner side (inputs in, seg/seg_dp/an/frame_tick out)
interface hex_7seg_scan_if #(
  parameter int N_DIGITS = 4
) ();

  logic                    en;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp;
  logic [N_DIGITS-1:0]     blank;
  logic                    lzb;
  logic [6:0]              seg;
  logic                    seg_dp;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_tick;

  modport master (
    output en, value, dp, blank, lzb,
    input  seg, seg_dp, an, frame_tick
  );

  modport slave (
    input  en, value, dp, blank, lzb,
    output seg, seg_dp, an, frame_tick
  );

endinterface

// File: rtl/hex_7seg_scan_glyph.sv
// hex_7seg_glyph: combinational nibble-to-segment decoder.
//   nibble : hex digit 0..F
//   seg    : segment pattern, seg[0]=a .. seg[6]=g; inverted when ACTIVE_LOW
module hex_7seg_glyph
  import hex7seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = ACTIVE_LOW ? ~glyph(nibble) : glyph(nibble);
  end

endmodule

// File: rtl/hex_7seg_scan.sv
// hex_7seg_scan: time-multiplexed N-digit common-anode 7-segment driver.
//   clk, rst_n      : clock, synchronous active-low reset
//   en              : scan enable (pos holds and outputs go dark when low)
//   value/dp/blank  : per-digit nibble, decimal point, force-dark; latched
//   lzb             : leading-zero blanking; latched with the others
//   seg, seg_dp     : shared segment pins (SEG_ACTIVE_LOW polarity)
//   an              : anode enables, an[i] drives digit i (AN_ACTIVE_LOW)
//   frame_tick      : one-cycle pulse after each shadow load
module hex_7seg_scan
  import hex7seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD_CYCLES   = 2000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int TOTAL = N_DIGITS * REFRESH_DIV;
  localparam int PW    = $clog2(TOTAL);
  localparam int SW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PW-1:0]       POS_LAST = PW'(TOTAL - 1);
  localparam logic [PW-1:0]       DIV_P    = PW'(REFRESH_DIV);
  localparam logic [PW-1:0]       GUARD_P  = PW'(GUARD_CYCLES);
  localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]         pos_reg;
  logic [4*N_DIGITS-1:0] value_reg;
  logic [N_DIGITS-1:0]   dp_reg;
  logic [N_DIGITS-1:0]   blank_reg;
  logic                  lzb_reg;
  logic [6:0]            seg_reg;
  logic                  seg_dp_reg;
  logic [N_DIGITS-1:0]   an_reg;
  logic                  frame_tick_reg;

  logic                  load;
  logic [SW-1:0]         slot;
  logic [PW-1:0]         phase;

  // On the loading edge the display decision uses the incoming inputs, so
  // a zero-length guard can never show the previous frame's first digit.
  logic [4*N_DIGITS-1:0] cur_value;
  logic [N_DIGITS-1:0]   cur_dp;
  logic [N_DIGITS-1:0]   cur_blank;
  logic                  cur_lzb;

  logic [3:0]            nib [N_DIGITS];
  logic [N_DIGITS-1:0]   upper_zero;  // nibbles i..N-1 are all zero
  logic [3:0]            cur_nib;
  logic [6:0]            glyph_seg;

  logic [6:0]            seg_next;
  logic                  seg_dp_next;
  logic [N_DIGITS-1:0]   an_next;

  assign load      = en && (pos_reg == '0);
  assign slot      = SW'(pos_reg / DIV_P);
  assign phase     = pos_reg % DIV_P;
  assign cur_value = load ? value : value_reg;
  assign cur_dp    = load ? dp    : dp_reg;
  assign cur_blank = load ? blank : blank_reg;
  assign cur_lzb   = load ? lzb   : lzb_reg;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign nib[gi] = cur_value[4*gi +: 4];
    if (gi == N_DIGITS - 1) begin : g_top
      assign upper_zero[gi] = (nib[gi] == 4'h0);
    end else begin : g_lower
      assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
    end
  end

  assign cur_nib = nib[slot];

  hex_7seg_glyph #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_glyph (
    .nibble (cur_nib),
    .seg    (glyph_seg)
  );

  always_comb begin
    an_next     = AN_OFF;
    seg_next    = SEG_OFF;
    seg_dp_next = DP_OFF;
    if (en && (phase >= GUARD_P) && !cur_blank[slot]) begin
      if (cur_lzb && (slot != '0) && upper_zero[slot]) begin
        // Leading zero: segments stay dark, only a requested dp is lit.
        if (cur_dp[slot]) begin
          an_next[slot] = ~AN_ACTIVE_LOW;
          seg_dp_next   = ~DP_OFF;
        end
      end else begin
        an_next[slot] = ~AN_ACTIVE_LOW;
        seg_next      = glyph_seg;
        if (cur_dp[slot]) begin
          seg_dp_next = ~DP_OFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_reg        <= '0;
      value_reg      <= '0;
      dp_reg         <= '0;
      blank_reg      <= '0;
      lzb_reg        <= 1'b0;
      seg_reg        <= SEG_OFF;
      seg_dp_reg     <= DP_OFF;
      an_reg         <= AN_OFF;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= load;
      if (en) begin
        pos_reg <= (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
      end
      if (load) begin
        value_reg <= value;
        dp_reg    <= dp;
        blank_reg <= blank;
        lzb_reg   <= lzb;
      end
      seg_reg    <= seg_next;
      seg_dp_reg <= seg_dp_next;
      an_reg     <= an_next;
    end
  end

  assign seg        = seg_reg;
  assign seg_dp     = seg_dp_reg;
  assign an         = an_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_hex_7seg_scan.sv
// tb_hex_7seg_scan: directed bench for hex_7seg_scan with N=4, DIV=8,
// GUARD=2 (32-cycle frame), active-low segments and anodes.
module tb_hex_7seg_scan;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hex_7seg_scan_if #(.N_DIGITS(N)) bus ();

  hex_7seg_scan #(
    .N_DIGITS       (N),
    .REFRESH_DIV    (DIV),
    .GUARD_CYCLES   (GUARD),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus.en),
    .value      (bus.value),
    .dp         (bus.dp),
    .blank      (bus.blank),
    .lzb        (bus.lzb),
    .seg        (bus.seg),
    .seg_dp     (bus.seg_dp),
    .an         (bus.an),
    .frame_tick (bus.frame_tick)
  );

  // Active-high glyphs as listed for the display, gfedcba.
  logic [6:0] glyph_hi [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Expected pin values per digit during its drive window.
  logic [6:0] exp_seg [N];
  logic       exp_lit [N];   // anode expected on
  logic       exp_dpl [N];   // seg_dp pin level

  int checks = 0;
  int errors = 0;
  int pos_m  = 0;            // pos sampled by the next edge

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  32'(bus.an),         32'hF);
    check({tag, "_seg"}, 32'(bus.seg),        32'h7F);
    check({tag, "_dp"},  32'(bus.seg_dp),     32'h1);
    check({tag, "_ft"},  32'(bus.frame_tick), 32'h0);
  endtask

  task automatic step_check();
    int         slot;
    int         phase;
    logic [3:0] an_w;
    logic [6:0] seg_w;
    logic       dp_w;
    step();
    slot  = pos_m / DIV;
    phase = pos_m % DIV;
    an_w  = 4'hF;
    seg_w = 7'h7F;
    dp_w  = 1'b1;
    if (phase >= GUARD) begin
      if (exp_lit[slot]) an_w[slot] = 1'b0;
      seg_w = exp_seg[slot];
      dp_w  = exp_dpl[slot];
    end
    check($sformatf("an@%0d", pos_m),  32'(bus.an),         32'(an_w));
    check($sformatf("seg@%0d", pos_m), 32'(bus.seg),        32'(seg_w));
    check($sformatf("dp@%0d", pos_m),  32'(bus.seg_dp),     32'(dp_w));
    check($sformatf("ft@%0d", pos_m),  32'(bus.frame_tick), 32'(pos_m == 0));
    pos_m = (pos_m + 1) % FRAME;
  endtask

  task automatic run_frame(input string name);
    for (int i = 0; i < FRAME; i++) step_check();
    $display("frame %s value=%h checks=%0d errors=%0d", name, bus.value, checks, errors);
  endtask

  task automatic set_plain(input logic [15:0] v);
    bus.value = v;
    for (int i = 0; i < N; i++) begin
      exp_seg[i] = ~glyph_hi[v[4*i +: 4]];
      exp_lit[i] = 1'b1;
      exp_dpl[i] = 1'b1;
    end
  endtask

  task automatic set_1234();
    bus.value = 16'h1234;
    exp_seg   = '{7'h19, 7'h30, 7'h24, 7'h79};  // '4','3','2','1' inverted
    exp_lit   = '{1'b1, 1'b1, 1'b1, 1'b1};
    exp_dpl   = '{1'b1, 1'b1, 1'b1, 1'b1};
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.dp    = 4'b0000;
    bus.blank = 4'b0000;
    bus.lzb   = 1'b0;
    set_1234();
    step();
    step();
    check_dark("reset");

    // Release: first edge loads shadows, then 2 guard + 6 drive per slot.
    rst_n = 1'b1;
    pos_m = 0;
    run_frame("startup_a");
    run_frame("startup_b");

    // Sweep every glyph on digit 0.
    for (int v = 0; v < 16; v++) begin
      set_plain(16'(v));
      run_frame($sformatf("sweep_%0d", v));
    end

    // Mid-frame input change must not tear the displayed frame.
    set_1234();
    run_frame("pre_tear");
    for (int i = 0; i < 11; i++) step_check();
    bus.value = 16'hABCD;
    for (int i = 0; i < 21; i++) step_check();
    $display("frame tear_hold value=%h checks=%0d errors=%0d", bus.value, checks, errors);
    set_plain(16'hABCD);
    run_frame("after_tear");

    // Leading-zero blanking with a dp on the top digit.
    bus.value = 16'h0050;
    bus.dp    = 4'b1000;
    bus.lzb   = 1'b1;
    exp_seg   = '{7'h40, ~7'h6D, 7'h7F, 7'h7F};
    exp_lit   = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_dpl   = '{1'b1, 1'b1, 1'b1, 1'b0};
    run_frame("lzb");
    bus.dp  = 4'b0000;
    bus.lzb = 1'b0;

    // Blank digit 1, then pause the scan at pos 12.
    set_1234();
    bus.blank  = 4'b0010;
    exp_seg[1] = 7'h7F;
    exp_lit[1] = 1'b0;
    run_frame("blank");
    for (int i = 0; i < 12; i++) step_check();
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_dark($sformatf("hold%0d", i));
    end
    $display("pause at pos=%0d checks=%0d errors=%0d", pos_m, checks, errors);
    bus.en = 1'b1;
    for (int i = 0; i < 20; i++) step_check();
    run_frame("blank_after_pause");
    bus.blank = 4'b0000;

    // Reset pulse while digit 0 is being driven.
    set_1234();
    run_frame("pre_reset");
    for (int i = 0; i < 5; i++) step_check();
    rst_n = 1'b0;
    step();
    check_dark("mid_reset");
    rst_n = 1'b1;
    pos_m = 0;
    run_frame("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
